// File: rtl/fibonacci_seq_gen_if.sv
// Handshake bundle for fibonacci_seq_gen: start/seed request side
// and valid/ready term stream with status flags.
interface fibonacci_seq_gen_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic             start;
    logic [WIDTH-1:0] seed0;
    logic [WIDTH-1:0] seed1;
    logic [CNT_W-1:0] num_terms;
    logic [WIDTH-1:0] fib;
    logic             valid;
    logic             ready;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output start, seed0, seed1, num_terms, ready,
        input  fib, valid, busy, done, overflow
    );

    modport slave (
        input  start, seed0, seed1, num_terms, ready,
        output fib, valid, busy, done, overflow
    );
endinterface

// File: rtl/fibonacci_seq_gen.sv
// Fibonacci term generator with valid/ready output stream.
// Define FIB_SATURATE_EN to clamp overflowed terms to all-ones.
module fibonacci_seq_gen #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    fibonacci_seq_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    logic             tag_cur;
    logic             tag_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_lat;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;

    logic [WIDTH:0]   sum;
    logic             tag_sum;
    logic [WIDTH-1:0] sum_term;
    logic             hs;
    logic             last;

    assign sum     = {1'b0, cur} + {1'b0, nxt};
    assign tag_sum = sum[WIDTH] | tag_cur | tag_nxt;

`ifdef FIB_SATURATE_EN
    assign sum_term = tag_sum ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    assign sum_term = sum[WIDTH-1:0];
`endif

    assign hs   = valid_q & bus.ready;
    assign last = (cnt == n_lat - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cur     <= '0;
            nxt     <= '0;
            tag_cur <= 1'b0;
            tag_nxt <= 1'b0;
            cnt     <= '0;
            n_lat   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        n_lat <= bus.num_terms;
                        cnt   <= '0;
                        ovf_q <= 1'b0;
                        if (bus.num_terms == '0) begin
                            // nothing to emit: fib keeps its old value
                            state   <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state   <= RUN;
                            cur     <= bus.seed0;
                            nxt     <= bus.seed1;
                            tag_cur <= 1'b0;
                            tag_nxt <= 1'b0;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (tag_cur) ovf_q <= 1'b1;
                        if (last) begin
                            state   <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cur     <= nxt;
                            tag_cur <= tag_nxt;
                            nxt     <= sum_term;
                            tag_nxt <= tag_sum;
                            cnt     <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.fib      = cur;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
endmodule
